// File: rtl/pipeline_decode_stage.sv
// RV32I instruction decode stage: register file, immediate generation and a
// registered ID/EX slot with valid/ready handshakes toward IF and EX.
module pipeline_decode_stage #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int BYPASS_EN = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  input  logic            reg_write_i,
  input  logic [4:0]      write_reg_i,
  input  logic [XLEN-1:0] write_data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] read_data1_o,
  output logic [XLEN-1:0] read_data2_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] offset_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic            illegal_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [XLEN-1:0]  regs_q [NUM_REGS];
  logic [IDX_W-1:0] rs1_idx, rs2_idx, wr_idx, hold1_idx, hold2_idx;
  logic             wr_en, load;
  logic [XLEN-1:0]  rdata1, rdata2;
  logic [31:0]      imm32;
  logic             illegal;
  logic [6:0]       opcode;

  logic            valid_q, valid_d, illegal_q, illegal_d;
  logic [XLEN-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, offset_q, offset_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [6:0]      opcode_q, opcode_d, funct7_q, funct7_d;
  logic [2:0]      funct3_q, funct3_d;

  assign opcode    = instruction_i[6:0];
  assign rs1_idx   = instruction_i[15 +: IDX_W];
  assign rs2_idx   = instruction_i[20 +: IDX_W];
  assign wr_idx    = write_reg_i[IDX_W-1:0];
  assign hold1_idx = rs1_q[IDX_W-1:0];
  assign hold2_idx = rs2_q[IDX_W-1:0];
  assign wr_en     = reg_write_i && (wr_idx != '0);
  assign ready_o   = !valid_q || ready_i;
  assign load      = valid_i && ready_o && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_idx] <= write_data_i;
    end
  end

  // wr_en already excludes index 0, so the bypass never forwards into x0.
  always_comb begin
    rdata1 = (rs1_idx == '0) ? '0 : regs_q[rs1_idx];
    rdata2 = (rs2_idx == '0) ? '0 : regs_q[rs2_idx];
    if (BYPASS_EN != 0 && wr_en && wr_idx == rs1_idx) rdata1 = write_data_i;
    if (BYPASS_EN != 0 && wr_en && wr_idx == rs2_idx) rdata2 = write_data_i;
  end

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR:
        imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
      OPC_STORE:
        imm32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      OPC_BRANCH:
        imm32 = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                 instruction_i[30:25], instruction_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {instruction_i[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                 instruction_i[20], instruction_i[30:21], 1'b0};
      OPC_OP:  imm32 = '0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    offset_d  = offset_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    illegal_d = illegal_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      pc_d      = pc_i;
      rd1_d     = rdata1;
      rd2_d     = rdata2;
      rs1_d     = instruction_i[19:15];
      rs2_d     = instruction_i[24:20];
      rd_d      = instruction_i[11:7];
      offset_d  = XLEN'($signed(imm32));
      opcode_d  = opcode;
      funct3_d  = instruction_i[14:12];
      funct7_d  = instruction_i[31:25];
      illegal_d = illegal;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Held operands track WB writes so EX sees current values once unstalled.
      if (wr_en && wr_idx == hold1_idx) rd1_d = write_data_i;
      if (wr_en && wr_idx == hold2_idx) rd2_d = write_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      offset_q  <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      offset_q  <= offset_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      illegal_q <= illegal_d;
    end
  end

  assign valid_o      = valid_q;
  assign pc_o         = pc_q;
  assign read_data1_o = rd1_q;
  assign read_data2_o = rd2_q;
  assign rs1_o        = rs1_q;
  assign rs2_o        = rs2_q;
  assign rd_o         = rd_q;
  assign offset_o     = offset_q;
  assign opcode_o     = opcode_q;
  assign funct3_o     = funct3_q;
  assign funct7_o     = funct7_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_pipeline_decode_stage.sv
// Directed bench for pipeline_decode_stage; a second instance runs with the
// WB bypass disabled so both read behaviours can be compared on shared stimulus.
module tb_pipeline_decode_stage;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        valid_i, flush_i, reg_write_i, ready_i;
  logic [31:0] instruction_i, pc_i, write_data_i;
  logic [4:0]  write_reg_i;

  logic        ready_o, valid_o, illegal_o;
  logic [31:0] pc_o, read_data1_o, read_data2_o, offset_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [2:0]  funct3_o;

  logic        nb_ready_o, nb_valid_o, nb_illegal_o;
  logic [31:0] nb_pc_o, nb_read_data1_o, nb_read_data2_o, nb_offset_o;
  logic [4:0]  nb_rs1_o, nb_rs2_o, nb_rd_o;
  logic [6:0]  nb_opcode_o, nb_funct7_o;
  logic [2:0]  nb_funct3_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  pipeline_decode_stage #(.XLEN(32), .NUM_REGS(32), .BYPASS_EN(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .instruction_i(instruction_i), .pc_i(pc_i), .flush_i(flush_i),
    .reg_write_i(reg_write_i), .write_reg_i(write_reg_i), .write_data_i(write_data_i),
    .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o),
    .read_data1_o(read_data1_o), .read_data2_o(read_data2_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .offset_o(offset_o),
    .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .illegal_o(illegal_o));

  pipeline_decode_stage #(.XLEN(32), .NUM_REGS(32), .BYPASS_EN(0)) dut_nb (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(nb_ready_o),
    .instruction_i(instruction_i), .pc_i(pc_i), .flush_i(flush_i),
    .reg_write_i(reg_write_i), .write_reg_i(write_reg_i), .write_data_i(write_data_i),
    .valid_o(nb_valid_o), .ready_i(ready_i), .pc_o(nb_pc_o),
    .read_data1_o(nb_read_data1_o), .read_data2_o(nb_read_data2_o),
    .rs1_o(nb_rs1_o), .rs2_o(nb_rs2_o), .rd_o(nb_rd_o), .offset_o(nb_offset_o),
    .opcode_o(nb_opcode_o), .funct3_o(nb_funct3_o), .funct7_o(nb_funct7_o),
    .illegal_o(nb_illegal_o));

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; flush_i = 1'b0; reg_write_i = 1'b0;
    write_reg_i = '0; write_data_i = '0;
  endtask

  task automatic test_reset();
    total_cnt++; if (valid_o !== 1'b0) $display("FAIL rst_valid got %0b want 0", valid_o); else pass_cnt++;
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL rst_ready got %0b want 1", ready_o); else pass_cnt++;
    total_cnt++; if (offset_o !== 32'h0) $display("FAIL rst_offset got %h want 0", offset_o); else pass_cnt++;
    total_cnt++; if (pc_o !== 32'h0) $display("FAIL rst_pc got %h want 0", pc_o); else pass_cnt++;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk_i);
      valid_i = 1'b1;
      instruction_i = (32'(i) << 20) | (32'(i) << 15) | 32'h33;
      pc_i = 32'(i * 4);
      tick();
      total_cnt++;
      if (read_data1_o !== 32'h0 || read_data2_o !== 32'h0)
        $display("FAIL rst_reg x%0d got %h/%h want 0/0", i, read_data1_o, read_data2_o);
      else pass_cnt++;
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_wb_then_load();
    @(negedge clk_i);
    reg_write_i = 1'b1; write_reg_i = 5'd5; write_data_i = 32'hDEADBEEF;
    tick();
    @(negedge clk_i);
    reg_write_i = 1'b0; valid_i = 1'b1; instruction_i = 32'hFFF28313; pc_i = 32'h100;
    tick();
    total_cnt++; if (valid_o !== 1'b1) $display("FAIL addi_valid got %0b want 1", valid_o); else pass_cnt++;
    total_cnt++; if (read_data1_o !== 32'hDEADBEEF) $display("FAIL addi_rd1 got %h want deadbeef", read_data1_o); else pass_cnt++;
    total_cnt++; if (nb_read_data1_o !== 32'hDEADBEEF) $display("FAIL addi_nb_rd1 got %h want deadbeef", nb_read_data1_o); else pass_cnt++;
    total_cnt++; if (offset_o !== 32'hFFFFFFFF) $display("FAIL addi_offset got %h want ffffffff", offset_o); else pass_cnt++;
    total_cnt++; if (rd_o !== 5'd6) $display("FAIL addi_rd got %0d want 6", rd_o); else pass_cnt++;
    total_cnt++; if (rs1_o !== 5'd5) $display("FAIL addi_rs1 got %0d want 5", rs1_o); else pass_cnt++;
    total_cnt++; if (opcode_o !== 7'h13) $display("FAIL addi_opcode got %h want 13", opcode_o); else pass_cnt++;
    total_cnt++; if (illegal_o !== 1'b0) $display("FAIL addi_illegal got %0b want 0", illegal_o); else pass_cnt++;
    total_cnt++; if (pc_o !== 32'h100) $display("FAIL addi_pc got %h want 100", pc_o); else pass_cnt++;
    @(negedge clk_i);
    valid_i = 1'b0; pc_i = 32'h999;
    tick();
    total_cnt++; if (valid_o !== 1'b0) $display("FAIL drain_valid got %0b want 0", valid_o); else pass_cnt++;
    total_cnt++; if (pc_o !== 32'h100) $display("FAIL drain_pc_kept got %h want 100", pc_o); else pass_cnt++;
  endtask

  task automatic test_bypass();
    @(negedge clk_i);
    reg_write_i = 1'b1; write_reg_i = 5'd7; write_data_i = 32'h55;
    valid_i = 1'b1; instruction_i = 32'h00738433; pc_i = 32'h104;
    tick();
    total_cnt++; if (read_data1_o !== 32'h55 || read_data2_o !== 32'h55)
      $display("FAIL byp_on got %h/%h want 55/55", read_data1_o, read_data2_o); else pass_cnt++;
    total_cnt++; if (nb_read_data1_o !== 32'h0 || nb_read_data2_o !== 32'h0)
      $display("FAIL byp_off got %h/%h want 0/0", nb_read_data1_o, nb_read_data2_o); else pass_cnt++;
    total_cnt++; if (offset_o !== 32'h0 || illegal_o !== 1'b0)
      $display("FAIL op_imm got %h/%0b want 0/0", offset_o, illegal_o); else pass_cnt++;
    @(negedge clk_i);
    reg_write_i = 1'b0;
    tick();
    total_cnt++; if (nb_read_data1_o !== 32'h55) $display("FAIL byp_off_next got %h want 55", nb_read_data1_o); else pass_cnt++;
  endtask

  task automatic test_stall_refresh();
    @(negedge clk_i);
    valid_i = 1'b1; instruction_i = 32'hFE912E23; pc_i = 32'h200;
    tick();
    total_cnt++; if (read_data2_o !== 32'h0) $display("FAIL sw_rd2_init got %h want 0", read_data2_o); else pass_cnt++;
    total_cnt++; if (rs2_o !== 5'd9 || funct3_o !== 3'd2 || funct7_o !== 7'h7F)
      $display("FAIL sw_fields got %0d/%0d/%h want 9/2/7f", rs2_o, funct3_o, funct7_o); else pass_cnt++;
    @(negedge clk_i);
    ready_i = 1'b0;
    reg_write_i = 1'b1; write_reg_i = 5'd9; write_data_i = 32'h1234;
    #1;
    total_cnt++; if (ready_o !== 1'b0) $display("FAIL stall_ready got %0b want 0", ready_o); else pass_cnt++;
    tick();
    total_cnt++; if (read_data2_o !== 32'h1234) $display("FAIL refresh_rd2 got %h want 1234", read_data2_o); else pass_cnt++;
    total_cnt++; if (nb_read_data2_o !== 32'h1234) $display("FAIL refresh_nb_rd2 got %h want 1234", nb_read_data2_o); else pass_cnt++;
    total_cnt++; if (offset_o !== 32'hFFFFFFFC) $display("FAIL sw_offset got %h want fffffffc", offset_o); else pass_cnt++;
    total_cnt++; if (valid_o !== 1'b1 || ready_o !== 1'b0 || pc_o !== 32'h200)
      $display("FAIL stall_hold got %0b/%0b/%h want 1/0/200", valid_o, ready_o, pc_o); else pass_cnt++;
    @(negedge clk_i);
    write_reg_i = 5'd2; write_data_i = 32'hAA;
    tick();
    total_cnt++; if (read_data1_o !== 32'hAA || read_data2_o !== 32'h1234)
      $display("FAIL refresh_rd1 got %h/%h want aa/1234", read_data1_o, read_data2_o); else pass_cnt++;
    @(negedge clk_i);
    write_reg_i = 5'd5; write_data_i = 32'h99;
    tick();
    total_cnt++; if (read_data1_o !== 32'hAA || read_data2_o !== 32'h1234)
      $display("FAIL refresh_other got %h/%h want aa/1234", read_data1_o, read_data2_o); else pass_cnt++;
  endtask

  task automatic test_flush();
    @(negedge clk_i);
    flush_i = 1'b1; valid_i = 1'b1;
    reg_write_i = 1'b1; write_reg_i = 5'd3; write_data_i = 32'h77;
    tick();
    total_cnt++; if (valid_o !== 1'b0 || ready_o !== 1'b1)
      $display("FAIL flush got valid %0b ready %0b want 0/1", valid_o, ready_o); else pass_cnt++;
    @(negedge clk_i);
    idle_inputs();
    ready_i = 1'b1;
    tick();
    total_cnt++; if (valid_o !== 1'b0) $display("FAIL flush_drop got %0b want 0", valid_o); else pass_cnt++;
  endtask

  task automatic test_illegal();
    @(negedge clk_i);
    valid_i = 1'b1; instruction_i = 32'h0001807F; pc_i = 32'h300;
    tick();
    total_cnt++; if (illegal_o !== 1'b1 || offset_o !== 32'h0)
      $display("FAIL illegal got %0b/%h want 1/0", illegal_o, offset_o); else pass_cnt++;
    total_cnt++; if (read_data1_o !== 32'h77) $display("FAIL flush_wb got %h want 77", read_data1_o); else pass_cnt++;
    total_cnt++; if (opcode_o !== 7'h7F || valid_o !== 1'b1)
      $display("FAIL illegal_opc got %h/%0b want 7f/1", opcode_o, valid_o); else pass_cnt++;
  endtask

  task automatic test_imm_formats();
    logic [31:0] instr_t [10] = '{32'hFE000EE3, 32'hFFDFF0EF, 32'h00000463, 32'h000000E3,
                                  32'h123450B7, 32'h80000017, 32'h7FF00067, 32'h0010006F,
                                  32'h0000106F, 32'h0000000F};
    logic [31:0] imm_t [10]   = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000008, 32'h00000800,
                                  32'h12345000, 32'h80000000, 32'h000007FF, 32'h00000800,
                                  32'h00001000, 32'h00000000};
    logic        ill_t [10]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      valid_i = 1'b1; instruction_i = instr_t[i]; pc_i = 32'h400 + 32'(i * 4);
      tick();
      total_cnt++;
      if (offset_o !== imm_t[i] || illegal_o !== ill_t[i])
        $display("FAIL imm_%0d instr %h got %h/%0b want %h/%0b", i, instr_t[i],
                 offset_o, illegal_o, imm_t[i], ill_t[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk_i);
    valid_i = 1'b1; instruction_i = 32'hFFF28313; pc_i = 32'h500;
    tick();
    @(negedge clk_i);
    valid_i = 1'b0; ready_i = 1'b0;
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    total_cnt++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || read_data1_o !== 32'h0)
      $display("FAIL async_rst got %0b/%0b/%h want 0/1/0", valid_o, ready_o, read_data1_o); else pass_cnt++;
    @(negedge clk_i);
    rst_i = 1'b0; ready_i = 1'b1; valid_i = 1'b1;
    tick();
    total_cnt++; if (read_data1_o !== 32'h0 || valid_o !== 1'b1)
      $display("FAIL rst_regfile got %h/%0b want 0/1", read_data1_o, valid_o); else pass_cnt++;
  endtask

  initial begin
    idle_inputs();
    ready_i = 1'b1; instruction_i = '0; pc_i = '0;
    #12;
    test_reset();
    test_wb_then_load();
    test_bypass();
    test_stall_refresh();
    test_flush();
    test_illegal();
    test_imm_formats();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
